apb_to_ahb: RTL and testbench

APB-completer to AHB-Lite-manager bridge. It lets an APB requester (debug/config master on the peripheral bus) issue single word transfers into the AHB-Lite fabric. The block sits on the APB side as a completer and drives the AHB-Lite fabric as its only manager. It is the reverse-direction companion of the AHB-to-APB bridge, and both buses share one clock.

---
 rtl/apb_to_ahb.sv | 153 +++++++++++++++
 tb/tb_apb_to_ahb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_ahb.sv
// APB completer to AHB-Lite manager bridge: one APB word access becomes one AHB SINGLE transfer.
// Optional wait-state watchdog with ABORT state when APB_TO_AHB_TIMEOUT_EN is defined.
module apb_to_ahb #(
   parameter int ADDRWIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [ADDRWIDTH-1:0] PADDR,
   input  logic [31:0]          PWDATA,
   output logic [31:0]          PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR,
   output logic [ADDRWIDTH-1:0] HADDR,
   output logic [1:0]           HTRANS,
   output logic [2:0]           HSIZE,
   output logic [2:0]           HBURST,
   output logic                 HWRITE,
   output logic [31:0]          HWDATA,
   input  logic [31:0]          HRDATA,
   input  logic                 HREADY,
   input  logic                 HRESP
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

`ifdef APB_TO_AHB_TIMEOUT_EN
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_ABORT} state_t;
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
   logic [15:0] cnt_q, cnt_d;
`else
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
`endif

   state_t               state_q, state_d;
   logic [ADDRWIDTH-3:0] addr_q, addr_d;
   logic                 wr_q, wr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic [1:0]           htrans_q;
   logic                 pready_q, pslverr_q;
   logic                 unused_paddr_lsb;

   assign unused_paddr_lsb = ^PADDR[1:0];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef APB_TO_AHB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (PSEL && !PENABLE) begin
               addr_d  = PADDR[ADDRWIDTH-1:2];
               wr_d    = PWRITE;
               wdata_d = PWDATA;
               state_d = S_ADDR;
`ifdef APB_TO_AHB_TIMEOUT_EN
               cnt_d   = 16'd0;
`endif
            end
         end
         S_ADDR: begin
            if (HREADY) state_d = S_DATA;
`ifdef APB_TO_AHB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_d >= TO_LIMIT) state_d = S_ABORT;
            end
`endif
         end
         S_DATA: begin
            // A first error cycle (HREADY=0, HRESP=1) is just another wait here.
            if (HREADY) begin
               err_d = HRESP;
               if (!wr_q) rdata_d = HRESP ? 32'd0 : HRDATA;
               state_d = S_RESP;
            end
`ifdef APB_TO_AHB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_d >= TO_LIMIT) state_d = S_ABORT;
            end
`endif
         end
         S_RESP: state_d = S_IDLE;
`ifdef APB_TO_AHB_TIMEOUT_EN
         S_ABORT: begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = S_RESP;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are flops loaded from next-state so nothing combinational reaches a port.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
         htrans_q  <= TRANS_IDLE;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
`ifdef APB_TO_AHB_TIMEOUT_EN
         cnt_q     <= 16'd0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         htrans_q  <= (state_d == S_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
         pready_q  <= (state_d == S_RESP);
         pslverr_q <= (state_d == S_RESP) && err_d;
`ifdef APB_TO_AHB_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign HADDR   = {addr_q, 2'b00};
   assign HTRANS  = htrans_q;
   assign HSIZE   = 3'b010;
   assign HBURST  = 3'b000;
   assign HWRITE  = wr_q;
   assign HWDATA  = wdata_q;
   assign PRDATA  = rdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_to_ahb.sv
// Directed bench for apb_to_ahb: APB requester tasks plus a configurable AHB-Lite slave model.
module tb_apb_to_ahb;

   logic        HCLK, HRESETn;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic        HWRITE, HREADY, HRESP;

   int n_cmp = 0;
   int n_mis = 0;

   apb_to_ahb #(.ADDRWIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWRITE(HWRITE),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Slave configuration (written by main flow) and observations (written by slave).
   int          s_aw = 0, s_dw = 0;
   bit          s_err = 0, s_hang = 0;
   logic [31:0] s_rdata = 32'h0;
   int          xfers = 0;
   logic [31:0] rec_addr = 32'h0, rec_wdata = 32'h0;
   logic        rec_write = 1'b0;

   initial begin
      bit dp, last_ns, last_hr, rst_at_edge;
      int acnt, wcnt;
      dp = 0; last_ns = 0; last_hr = 0; acnt = 0; wcnt = 0;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
      forever begin
         @(posedge HCLK);
         rst_at_edge = HRESETn;
         #1;
         if (!rst_at_edge) begin
            dp = 0; acnt = 0;
         end else begin
            if (dp && last_hr) dp = 0;
            if (last_ns && last_hr) begin dp = 1; wcnt = 0; xfers++; end
         end
         HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
         if (s_hang) begin
            HREADY = 1'b0; acnt = 0;
         end else if (HTRANS == 2'b10) begin
            rec_addr = HADDR; rec_write = HWRITE;
            HREADY = (acnt >= s_aw); acnt++;
         end else if (dp) begin
            acnt = 0;
            if (wcnt < s_dw) HREADY = 1'b0;
            else if (s_err && wcnt == s_dw) begin HREADY = 1'b0; HRESP = 1'b1; end
            else if (s_err) begin HREADY = 1'b1; HRESP = 1'b1; end
            else if (!rec_write) HRDATA = s_rdata;
            else rec_wdata = HWDATA;
            wcnt++;
         end else acnt = 0;
         last_ns = (HTRANS == 2'b10);
         last_hr = HREADY;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge HCLK); #1; end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after PREADY (or after the limit).
   task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output int acc, output int ns_acc, output logic [31:0] rd,
                           output bit err, output bit done);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      @(posedge HCLK); #1;
      PENABLE = 1'b1; PWDATA = ~d;
      acc = 0; ns_acc = 0; rd = 32'h0; err = 0; done = 0;
      while (!done && acc < 60) begin
         @(negedge HCLK);
         acc++;
         if (HTRANS == 2'b10 && ns_acc == 0) ns_acc = acc;
         if (PREADY) begin done = 1; rd = PRDATA; err = PSLVERR; end
         @(posedge HCLK); #1;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      int acc, ns, x0, npr;
      logic [31:0] rd;
      bit err, done, seen;
      HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = 32'h0; PWDATA = 32'h0;
      @(posedge HCLK); @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_htrans", 32'(HTRANS), 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'h0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_pready", 32'(PREADY), 32'h0);
      chk("rst_pslverr", 32'(PSLVERR), 32'h0);
      chk("rst_prdata", PRDATA, 32'h0);
      chk("hsize", 32'(HSIZE), 32'h2);
      chk("hburst", 32'(HBURST), 32'h0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      idle(2);

      // Zero-wait write
      s_aw = 0; s_dw = 0; s_err = 0;
      apb_xfer(1'b1, 32'h4000_0010, 32'hA5A5_5A5A, acc, ns, rd, err, done);
      chk("wr_done", 32'(done), 32'h1);
      chk("wr_cycles", 32'(acc), 32'd3);
      chk("wr_nonseq_cycle", 32'(ns), 32'd1);
      chk("wr_err", 32'(err), 32'h0);
      chk("wr_haddr", rec_addr, 32'h4000_0010);
      chk("wr_hwrite", 32'(rec_write), 32'h1);
      chk("wr_hwdata", rec_wdata, 32'hA5A5_5A5A);
      chk("wr_prdata_hold", rd, 32'h0);
      idle(2);

      // Read with 4 data-phase waits
      s_dw = 4; s_rdata = 32'h1234_5678;
      apb_xfer(1'b0, 32'h4000_0014, 32'h0, acc, ns, rd, err, done);
      chk("rd_cycles", 32'(acc), 32'd7);
      chk("rd_data", rd, 32'h1234_5678);
      chk("rd_err", 32'(err), 32'h0);
      chk("rd_haddr", rec_addr, 32'h4000_0014);
      chk("rd_hwrite", 32'(rec_write), 32'h0);
      idle(1);

      // Unaligned address with 2 address-phase waits
      s_aw = 2; s_dw = 0; s_rdata = 32'hCAFE_F00D;
      apb_xfer(1'b0, 32'h4000_001B, 32'h0, acc, ns, rd, err, done);
      chk("aw_cycles", 32'(acc), 32'd5);
      chk("aw_haddr", rec_addr, 32'h4000_0018);
      chk("aw_data", rd, 32'hCAFE_F00D);
      idle(1);

      // Two-cycle error response on a read
      s_aw = 0; s_err = 1;
      apb_xfer(1'b0, 32'h4000_0050, 32'h0, acc, ns, rd, err, done);
      chk("err_cycles", 32'(acc), 32'd4);
      chk("err_pslverr", 32'(err), 32'h1);
      chk("err_prdata", rd, 32'h0);
      s_err = 0;
      idle(1);

      // Back-to-back write then read, setup right after PREADY
      x0 = xfers;
      apb_xfer(1'b1, 32'h4000_0020, 32'h1111_2222, acc, ns, rd, err, done);
      chk("b2b_wr_cycles", 32'(acc), 32'd3);
      chk("b2b_wr_hwdata", rec_wdata, 32'h1111_2222);
      s_rdata = 32'h3333_4444;
      apb_xfer(1'b0, 32'h4000_0024, 32'h0, acc, ns, rd, err, done);
      chk("b2b_rd_cycles", 32'(acc), 32'd3);
      chk("b2b_rd_nonseq_cycle", 32'(ns), 32'd1);
      chk("b2b_rd_data", rd, 32'h3333_4444);
      chk("b2b_rd_haddr", rec_addr, 32'h4000_0024);
      chk("b2b_xfer_count", 32'(xfers - x0), 32'd2);
      idle(2);

      // Reset asserted while in the data phase
      s_dw = 5;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4000_0030; PWDATA = 32'h5555_AAAA;
      @(posedge HCLK); #1; PENABLE = 1'b1;
      @(negedge HCLK); chk("mid_in_addr", 32'(HTRANS), 32'h2);
      @(posedge HCLK); #1;
      @(posedge HCLK); #1;
      HRESETn = 1'b0;
      @(posedge HCLK); #1;
      HRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge HCLK);
      chk("mid_rst_htrans", 32'(HTRANS), 32'h0);
      chk("mid_rst_pready", 32'(PREADY), 32'h0);
      chk("mid_rst_haddr", HADDR, 32'h0);
      npr = 0;
      repeat (8) begin @(negedge HCLK); if (PREADY) npr++; end
      chk("mid_rst_no_pready", 32'(npr), 32'h0);
      @(posedge HCLK); #1;
      s_dw = 0;
      apb_xfer(1'b1, 32'h4000_0034, 32'h7777_8888, acc, ns, rd, err, done);
      chk("post_rst_cycles", 32'(acc), 32'd3);
      chk("post_rst_hwdata", rec_wdata, 32'h7777_8888);
      chk("post_rst_err", 32'(err), 32'h0);
      idle(2);

      // Slave stuck with HREADY=0
      s_hang = 1;
      apb_xfer(1'b0, 32'h4000_0040, 32'h0, acc, ns, rd, err, done);
`ifdef APB_TO_AHB_TIMEOUT_EN
      chk("to_done", 32'(done), 32'h1);
      chk("to_cycles", 32'(acc), 32'd10);
      chk("to_pslverr", 32'(err), 32'h1);
      chk("to_prdata", rd, 32'h0);
      s_hang = 0;
`else
      chk("hang_no_pready", 32'(done), 32'h0);
      s_hang = 0;
      seen = 0;
      repeat (6) begin @(negedge HCLK); if (PREADY) seen = 1; end
      chk("hang_release_pready", 32'(seen), 32'h1);
      @(posedge HCLK); #1;
`endif
      idle(2);

      s_rdata = 32'h0BAD_CAFE;
      apb_xfer(1'b0, 32'h4000_0044, 32'h0, acc, ns, rd, err, done);
      chk("final_cycles", 32'(acc), 32'd3);
      chk("final_data", rd, 32'h0BAD_CAFE);
      chk("final_err", 32'(err), 32'h0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
